pixel_scan_controller: RTL and testbench

PIXEL_SCAN_CONTROLLER -- requirements
Module: pixel_scan_controller

---
 rtl/pixel_scan_controller.sv | 150 +++++++++++++++
 tb/tb_pixel_scan_controller.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scan_controller.sv
// Raster scanner that walks a (MAX_X+1)x(MAX_Y+1) grid, classifies each cell from the
// generator responses and offers one pixel at a time over a valid/ready handshake.
module pixel_scan_controller #(
  parameter int MAX_X = 15,
  parameter int MAX_Y = 15
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] x,
  output logic [3:0] y,
  input  logic       isBorder,
  input  logic       isApple,
  input  logic       isBody,
  input  logic       isHead,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [2:0] pix_code,
  output logic [3:0] pix_x,
  output logic [3:0] pix_y,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

  localparam logic [3:0] LAST_X = 4'(MAX_X);
  localparam logic [3:0] LAST_Y = 4'(MAX_Y);

  localparam logic [2:0] CODE_EMPTY  = 3'd0;
  localparam logic [2:0] CODE_BORDER = 3'd1;
  localparam logic [2:0] CODE_APPLE  = 3'd2;
  localparam logic [2:0] CODE_BODY   = 3'd3;
  localparam logic [2:0] CODE_HEAD   = 3'd4;

  state_t     state_reg, state_next;
  logic [3:0] x_reg, x_next;
  logic [3:0] y_reg, y_next;
  logic [3:0] pix_x_reg, pix_x_next;
  logic [3:0] pix_y_reg, pix_y_next;
  logic [2:0] pix_code_reg, pix_code_next;
  logic       pix_valid_reg, pix_valid_next;
  logic [7:0] frame_count_reg, frame_count_next;
  logic [2:0] code_sel;

  always_comb begin
    code_sel = CODE_EMPTY;
    if (isHead)        code_sel = CODE_HEAD;
    else if (isBody)   code_sel = CODE_BODY;
    else if (isApple)  code_sel = CODE_APPLE;
    else if (isBorder) code_sel = CODE_BORDER;
  end

  always_comb begin
    state_next       = state_reg;
    x_next           = x_reg;
    y_next           = y_reg;
    pix_x_next       = pix_x_reg;
    pix_y_next       = pix_y_reg;
    pix_code_next    = pix_code_reg;
    pix_valid_next   = pix_valid_reg;
    frame_count_next = frame_count_reg;

    case (state_reg)
      IDLE: begin
        x_next = 4'd0;
        y_next = 4'd0;
        if (start && !abort) state_next = SCAN;
      end
      SCAN: begin
        if (abort) begin
          state_next     = IDLE;
          x_next         = 4'd0;
          y_next         = 4'd0;
          pix_valid_next = 1'b0;
        end else begin
          pix_code_next  = code_sel;
          pix_x_next     = x_reg;
          pix_y_next     = y_reg;
          pix_valid_next = 1'b1;
          state_next     = HOLD;
        end
      end
      HOLD: begin
        // Abort beats a simultaneous handshake: the pixel is gone but the frame is not counted.
        if (abort) begin
          state_next     = IDLE;
          x_next         = 4'd0;
          y_next         = 4'd0;
          pix_valid_next = 1'b0;
        end else if (pix_valid_reg && pix_ready) begin
          pix_valid_next = 1'b0;
          if (x_reg == LAST_X && y_reg == LAST_Y) begin
            state_next = DONE;
            x_next     = 4'd0;
            y_next     = 4'd0;
          end else begin
            state_next = SCAN;
            if (x_reg == LAST_X) begin
              x_next = 4'd0;
              y_next = y_reg + 4'd1;
            end else begin
              x_next = x_reg + 4'd1;
            end
          end
        end
      end
      DONE: begin
        frame_count_next = frame_count_reg + 8'd1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_reg       <= IDLE;
      x_reg           <= 4'd0;
      y_reg           <= 4'd0;
      pix_x_reg       <= 4'd0;
      pix_y_reg       <= 4'd0;
      pix_code_reg    <= CODE_EMPTY;
      pix_valid_reg   <= 1'b0;
      frame_count_reg <= 8'd0;
    end else begin
      state_reg       <= state_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      pix_x_reg       <= pix_x_next;
      pix_y_reg       <= pix_y_next;
      pix_code_reg    <= pix_code_next;
      pix_valid_reg   <= pix_valid_next;
      frame_count_reg <= frame_count_next;
    end
  end

  assign x           = x_reg;
  assign y           = y_reg;
  assign pix_x       = pix_x_reg;
  assign pix_y       = pix_y_reg;
  assign pix_code    = pix_code_reg;
  assign pix_valid   = pix_valid_reg;
  assign frame_count = frame_count_reg;
  assign busy        = (state_reg != IDLE);
  assign frame_done  = (state_reg == DONE);

endmodule

// File: tb/tb_pixel_scan_controller.sv
// Bench for pixel_scan_controller: expected pixels are queued by the stimulus and
// popped by a monitor on every handshake; a 2x2 instance exercises frame_count wrap.
module tb_pixel_scan_controller;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pix_ready = 1'b0;
  logic [3:0] x, y, pix_x, pix_y;
  logic       isBorder, isApple, isBody, isHead;
  logic       pix_valid, busy, frame_done;
  logic [2:0] pix_code;
  logic [7:0] frame_count;

  logic       force_en = 1'b0;
  logic       f_border = 1'b0, f_apple = 1'b0, f_body = 1'b0, f_head = 1'b0;

  logic       s_start = 1'b0;
  logic [3:0] s_x, s_y, s_pix_x, s_pix_y;
  logic       s_pix_valid, s_busy, s_frame_done;
  logic [2:0] s_pix_code;
  logic [7:0] s_frame_count;

  typedef struct packed {
    logic [2:0] code;
    logic [3:0] px;
    logic [3:0] py;
  } pix_t;

  pix_t sb_q[$];
  pix_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   fd_count = 0;

  always #5 clk = ~clk;

  // Generator stand-in: a plain border ring unless the bench forces the responses.
  assign isBorder = force_en ? f_border : (x == 4'd0 || x == 4'd15 || y == 4'd0 || y == 4'd15);
  assign isApple  = force_en ? f_apple : 1'b0;
  assign isBody   = force_en ? f_body  : 1'b0;
  assign isHead   = force_en ? f_head  : 1'b0;

  pixel_scan_controller dut (
    .clk(clk), .nRst(nRst), .start(start), .abort(abort),
    .x(x), .y(y),
    .isBorder(isBorder), .isApple(isApple), .isBody(isBody), .isHead(isHead),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_code(pix_code),
    .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  pixel_scan_controller #(.MAX_X(1), .MAX_Y(1)) u_small (
    .clk(clk), .nRst(nRst), .start(s_start), .abort(1'b0),
    .x(s_x), .y(s_y),
    .isBorder(1'b0), .isApple(1'b0), .isBody(1'b0), .isHead(1'b0),
    .pix_valid(s_pix_valid), .pix_ready(1'b1), .pix_code(s_pix_code),
    .pix_x(s_pix_x), .pix_y(s_pix_y),
    .busy(s_busy), .frame_done(s_frame_done), .frame_count(s_frame_count)
  );

  always @(negedge clk) begin
    if (nRst && pix_valid && pix_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pixel got code=%0d at (%0d,%0d) exp none", pix_code, pix_x, pix_y);
      end else begin
        mon_e = sb_q.pop_front();
        if (pix_code !== mon_e.code || pix_x !== mon_e.px || pix_y !== mon_e.py) begin
          failures++;
          $display("FAIL pixel got code=%0d at (%0d,%0d) exp code=%0d at (%0d,%0d)",
                   pix_code, pix_x, pix_y, mon_e.code, mon_e.px, mon_e.py);
        end else begin
          $display("pix (%0d,%0d) code=%0d ok", pix_x, pix_y, pix_code);
        end
      end
    end
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] border_code(input int cx, input int cy);
    return (cx == 0 || cx == 15 || cy == 0 || cy == 15) ? 3'd1 : 3'd0;
  endfunction

  task automatic push_pix(input logic [2:0] code, input int px, input int py);
    pix_t p;
    p.code = code;
    p.px   = 4'(px);
    p.py   = 4'(py);
    sb_q.push_back(p);
  endtask

  // Raster-order border-frame pixels expected before the n-th one.
  task automatic push_prefix(input int n);
    for (int i = 0; i < n; i++) push_pix(border_code(i % 16, i / 16), i % 16, i / 16);
  endtask

  // Accept pixels one at a time until (tx,ty) is offered; leaves it held with pix_ready=0.
  task automatic run_to(input int tx, input int ty);
    bit hit = 1'b0;
    pix_ready = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      tick();
      if (pix_valid) begin
        if (pix_x == 4'(tx) && pix_y == 4'(ty)) hit = 1'b1;
        else begin
          pix_ready = 1'b1;
          tick();
          pix_ready = 1'b0;
        end
      end
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL run_to_timeout got=none exp=(%0d,%0d)", tx, ty);
    end
  endtask

  initial begin
    int lat;
    int fd0;

    // Reset state
    nRst = 1'b0;
    repeat (2) tick();
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    nRst = 1'b1;
    tick();

    // Full frame with continuous ready
    push_prefix(256);
    fd0 = fd_count;
    pix_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 600; i++) begin
      tick();
      if (i == 3) check("busy_in_frame", busy, 1);
      if (frame_done) begin
        lat = i;
        break;
      end
    end
    check("frame_done_latency", lat, 512);
    tick();
    pix_ready = 1'b0;
    check("frame_done_one_cycle", frame_done, 0);
    check("frame_count_after_1", frame_count, 1);
    check("busy_after_frame", busy, 0);
    check("frame_done_pulses", fd_count - fd0, 1);
    check("queue_drained_frame", sb_q.size(), 0);

    // Back-pressure at (2,0), then abort at (3,2)
    push_prefix(35);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to(2, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", pix_valid, 1);
      check("stall_pix_x", pix_x, 2);
      check("stall_pix_y", pix_y, 0);
      check("stall_x", x, 2);
    end
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    check("x_after_stall", x, 3);
    run_to(3, 2);
    fd0 = fd_count;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_x", x, 0);
    check("abort_y", y, 0);
    check("abort_valid", pix_valid, 0);
    repeat (3) tick();
    check("abort_no_done", fd_count - fd0, 0);
    check("abort_frame_count", frame_count, 1);
    check("queue_drained_abort", sb_q.size(), 0);

    // Restart from (0,0), reset mid-frame in HOLD at (5,3)
    push_prefix(53);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to(5, 3);
    nRst = 1'b0;
    tick();
    nRst = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_x", x, 0);
    check("midrst_y", y, 0);
    check("midrst_pix_x", pix_x, 0);
    check("midrst_pix_y", pix_y, 0);
    check("midrst_pix_code", pix_code, 0);
    check("midrst_valid", pix_valid, 0);
    check("midrst_frame_count", frame_count, 0);
    check("queue_drained_rst", sb_q.size(), 0);

    // Priority encoding; last pixel sees abort and handshake on one edge
    force_en = 1'b1;
    fd0 = fd_count;
    f_head = 1'b1; f_body = 1'b0; f_apple = 1'b1; f_border = 1'b1;
    push_pix(3'd4, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pix_ready = 1'b1; tick(); pix_ready = 1'b0;
    f_head = 1'b0;
    push_pix(3'd2, 1, 0);
    tick();
    pix_ready = 1'b1; tick(); pix_ready = 1'b0;
    f_body = 1'b1; f_border = 1'b0;
    push_pix(3'd3, 2, 0);
    tick();
    pix_ready = 1'b1; tick(); pix_ready = 1'b0;
    f_body = 1'b0; f_apple = 1'b0; f_border = 1'b1;
    push_pix(3'd1, 3, 0);
    tick();
    pix_ready = 1'b1; tick(); pix_ready = 1'b0;
    f_border = 1'b0;
    push_pix(3'd0, 4, 0);
    tick();
    pix_ready = 1'b1;
    abort = 1'b1;
    tick();
    pix_ready = 1'b0;
    abort = 1'b0;
    check("hs_abort_busy", busy, 0);
    check("hs_abort_x", x, 0);
    check("hs_abort_valid", pix_valid, 0);
    tick();
    check("hs_abort_no_done", fd_count - fd0, 0);
    check("hs_abort_frame_count", frame_count, 0);
    check("queue_drained_prio", sb_q.size(), 0);
    force_en = 1'b0;

    // start with abort in IDLE stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", busy, 0);
    tick();
    check("start_abort_idle_2", busy, 0);

    // Frame counter wrap on the 2x2 instance
    for (int f = 1; f <= 256; f++) begin
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (s_frame_done) begin
          lat = i;
          break;
        end
      end
      check("small_frame_latency", lat, 8);
      tick();
      if (f == 1)   check("small_count_1", s_frame_count, 1);
      if (f == 255) check("small_count_255", s_frame_count, 255);
      if (f == 256) check("small_count_wrap", s_frame_count, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
